// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage datapath: funct3 codes, FSM states, size helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Access size in bytes; the unused 111 code falls into the 8-byte bucket.
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        logic [3:0] sz;
        case (f3)
            F3_B, F3_BU: sz = 4'd1;
            F3_H, F3_HU: sz = 4'd2;
            F3_W, F3_WU: sz = 4'd4;
            default:     sz = 4'd8;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: DEPTH_WORDS x 64 bits, byte-enable write, registered read.
// Latency: read data valid one edge after the index is presented; writes land on the edge.
// Backpressure: none; always accepts a read and an optional write every cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] idx_i,
    input  logic          we_i,
    input  logic [7:0]    be_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH_WORDS];
    logic [63:0] rdata_q;

    // Byte-lane write plus unconditional registered read; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_stage.sv
// RV64 memory stage: multi-cycle load/store into dmem_array with lane select and extension.
// Latency: LATENCY+2 cycles per access; load result registered LATENCY+1 edges after request.
// Backpressure: mem_stall holds upstream for LATENCY+1 cycles; DMEM_MISALIGN_CHK_EN adds misalign flag.
module data_mem_stage
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadEXMEM,
    input  logic        MemWriteEXMEM,
    input  logic [2:0]  funct3EXMEM,
    input  logic [63:0] alu_resultEXMEM,
    input  logic [63:0] write_dataEXMEM,
    output logic [63:0] read_data,
    output logic        mem_stall
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     read_data_q, read_data_d;
    logic            stall_raw;

    logic            req;
    logic [3:0]      size;
    logic [2:0]      off_mask;
    logic [2:0]      lane;
    logic            acc_ok;
    logic [AW-1:0]   word_idx;
    logic [7:0]      be_mask;
    logic [7:0]      be;
    logic [63:0]     wdata_sh;
    logic            commit;
    logic            we;
    logic [63:0]     arr_rdata;
    logic [63:0]     lane_dat;
    logic [63:0]     load_ext;
    logic [63-AW-3:0] unused_addr_hi;

    assign req      = MemReadEXMEM | MemWriteEXMEM;
    assign size     = f3_size(funct3EXMEM);
    assign off_mask = 3'(size - 4'd1);
    assign word_idx = alu_resultEXMEM[AW+2:3];
    // Upper address bits simply wrap the address space.
    assign unused_addr_hi = alu_resultEXMEM[63:AW+3];

`ifdef DMEM_MISALIGN_CHK_EN
    logic mis;
    logic misalign_q, misalign_d;
    assign mis    = |(alu_resultEXMEM[2:0] & off_mask);
    assign lane   = alu_resultEXMEM[2:0];
    assign acc_ok = ~mis;
`else
    // Without checking, the offset is silently rounded down to the access size.
    assign lane   = alu_resultEXMEM[2:0] & ~off_mask;
    assign acc_ok = 1'b1;
`endif

    // Byte-enable mask for the access size, before shifting to the lane offset.
    always_comb begin
        be_mask = 8'hFF;
        case (size)
            4'd1:    be_mask = 8'h01;
            4'd2:    be_mask = 8'h03;
            4'd4:    be_mask = 8'h0F;
            default: be_mask = 8'hFF;
        endcase
    end

    assign be       = be_mask << lane;
    assign wdata_sh = write_dataEXMEM << {lane, 3'b000};
    assign commit   = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign we       = commit & MemWriteEXMEM & acc_ok;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk_i  (CLK),
        .idx_i  (word_idx),
        .we_i   (we),
        .be_i   (be),
        .wdata_i(wdata_sh),
        .rdata_o(arr_rdata)
    );

    assign lane_dat = arr_rdata >> {lane, 3'b000};

    // Select the addressed bytes and sign/zero extend to 64 bits.
    always_comb begin
        load_ext = '0;
        case (funct3EXMEM)
            F3_B:    load_ext = {{56{lane_dat[7]}},  lane_dat[7:0]};
            F3_H:    load_ext = {{48{lane_dat[15]}}, lane_dat[15:0]};
            F3_W:    load_ext = {{32{lane_dat[31]}}, lane_dat[31:0]};
            F3_D:    load_ext = lane_dat;
            F3_BU:   load_ext = {56'd0, lane_dat[7:0]};
            F3_HU:   load_ext = {48'd0, lane_dat[15:0]};
            F3_WU:   load_ext = {32'd0, lane_dat[31:0]};
            default: load_ext = '0;
        endcase
    end

    // Next-state, counter, stall and load-result logic for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        stall_raw   = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    stall_raw = 1'b1;
                    cnt_d     = CW'(LATENCY - 1);
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    // A store takes priority over a simultaneous load.
                    if (MemReadEXMEM && !MemWriteEXMEM) begin
                        read_data_d = acc_ok ? load_ext : 64'd0;
                    end
`ifdef DMEM_MISALIGN_CHK_EN
                    misalign_d = mis;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                // The request still visible here belongs to the finished instruction.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign read_data = read_data_q;
    // Stall drops the instant reset asserts, even if a request is still presented.
    assign mem_stall = stall_raw & RST;
`ifdef DMEM_MISALIGN_CHK_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int BYTES = DEPTH * 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadEXMEM;
    logic        MemWriteEXMEM;
    logic [2:0]  funct3EXMEM;
    logic [63:0] alu_resultEXMEM;
    logic [63:0] write_dataEXMEM;
    logic [63:0] read_data;
    logic        mem_stall;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [BYTES];
    logic [63:0] exp_rd;

    data_mem_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .MemReadEXMEM   (MemReadEXMEM),
        .MemWriteEXMEM  (MemWriteEXMEM),
        .funct3EXMEM    (funct3EXMEM),
        .alu_resultEXMEM(alu_resultEXMEM),
        .write_dataEXMEM(write_dataEXMEM),
        .read_data      (read_data),
        .mem_stall      (mem_stall)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mis(input logic [2:0] f3, input logic [63:0] addr);
        int sz = 1 << f3[1:0];
        int a  = int'(addr % 64'(BYTES));
`ifdef DMEM_MISALIGN_CHK_EN
        return (a % sz) != 0;
`else
        return (a % sz) != 0 && 1'b0;
`endif
    endfunction

    function automatic int model_addr(input logic [2:0] f3, input logic [63:0] addr);
        int sz = 1 << f3[1:0];
        int a  = int'(addr % 64'(BYTES));
        return a - (a % sz);
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
        int sz = 1 << f3[1:0];
        int a;
        logic [63:0] v = '0;
        if (f3 == 3'b111 || model_mis(f3, addr)) return 64'd0;
        a = model_addr(f3, addr);
        for (int i = 0; i < sz; i++) v = v | (64'(mdl[a + i]) << (8 * i));
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
        int sz = 1 << f3[1:0];
        int a;
        if (model_mis(f3, addr)) return;
        a = model_addr(f3, addr);
        for (int i = 0; i < sz; i++) mdl[a + i] = wd[8*i +: 8];
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the following IDLE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output int stalls, output logic [63:0] rd_done, output logic mis_done);
        MemReadEXMEM    = rd;
        MemWriteEXMEM   = wr;
        funct3EXMEM     = f3;
        alu_resultEXMEM = addr;
        write_dataEXMEM = wd;
        #1;
        stalls = 0;
        while (mem_stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge CLK);
        end
        rd_done = read_data;
`ifdef DMEM_MISALIGN_CHK_EN
        mis_done = misalign;
`else
        mis_done = 1'b0;
`endif
        @(negedge CLK);
        MemReadEXMEM  = 1'b0;
        MemWriteEXMEM = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        int          stalls;
        logic [63:0] got;
        logic        got_mis;
        logic        exp_mis = model_mis(f3, addr);
        if (wr) model_store(f3, addr, wd);
        else if (rd) exp_rd = model_load(f3, addr);
        access(rd, wr, f3, addr, wd, stalls, got, got_mis);
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(LAT + 1));
        check({tag, "_read_data"}, got, exp_rd);
        check({tag, "_misalign"}, 64'(got_mis), 64'(exp_mis));
        check({tag, "_hold"}, read_data, exp_rd);
    endtask

    initial begin
        logic [63:0] w;
        int          stalls;
        logic [63:0] got;
        logic        got_mis;

        RST = 1'b0;
        MemReadEXMEM = 1'b0;
        MemWriteEXMEM = 1'b0;
        funct3EXMEM = 3'b000;
        alu_resultEXMEM = '0;
        write_dataEXMEM = '0;
        exp_rd = '0;
        repeat (3) @(negedge CLK);
        check("reset_read_data", read_data, 64'd0);
        check("reset_stall", 64'(mem_stall), 64'd0);
`ifdef DMEM_MISALIGN_CHK_EN
        check("reset_misalign", 64'(misalign), 64'd0);
`endif
        RST = 1'b1;
        @(negedge CLK);

        // Give every byte a known value first.
        for (int i = 0; i < DEPTH; i++) begin
            w = {$urandom, $urandom};
            model_store(3'b011, 64'(i * 8), w);
            access(1'b0, 1'b1, 3'b011, 64'(i * 8), w, stalls, got, got_mis);
            check("fill_stall_cycles", 64'(stalls), 64'(LAT + 1));
        end

        do_op("sd_0x10", 1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788);
        do_op("ld_0x10", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
        check("ld_0x10_const", read_data, 64'h1122334455667788);
        do_op("sb_0x13", 1'b0, 1'b1, 3'b000, 64'h13, 64'hFF);
        do_op("lb_0x13", 1'b1, 1'b0, 3'b000, 64'h13, 64'h0);
        check("lb_0x13_const", read_data, 64'hFFFFFFFFFFFFFFFF);
        do_op("lbu_0x13", 1'b1, 1'b0, 3'b100, 64'h13, 64'h0);
        check("lbu_0x13_const", read_data, 64'h00000000000000FF);
        do_op("ld_0x10b", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
        check("ld_0x10b_const", read_data, 64'h11223344FF667788);
        do_op("sh_0x16", 1'b0, 1'b1, 3'b001, 64'h16, 64'h8001);
        do_op("lh_0x16", 1'b1, 1'b0, 3'b001, 64'h16, 64'h0);
        check("lh_0x16_const", read_data, 64'hFFFFFFFFFFFF8001);
        do_op("lwu_0x10", 1'b1, 1'b0, 3'b110, 64'h10, 64'h0);
        check("lwu_0x10_const", read_data, 64'h00000000FF667788);
        do_op("f3_111", 1'b1, 1'b0, 3'b111, 64'h10, 64'h0);

        do_op("sd_wrap", 1'b0, 1'b1, 3'b011, 64'h200, 64'hCAFEF00D12345678);
        do_op("ld_wrap", 1'b1, 1'b0, 3'b011, 64'h0, 64'h0);
        check("ld_wrap_const", read_data, 64'hCAFEF00D12345678);

        do_op("rd_wr_both", 1'b1, 1'b1, 3'b011, 64'h30, 64'h0102030405060708);
        do_op("ld_after_both", 1'b1, 1'b0, 3'b011, 64'h30, 64'h0);

        // Reset in the middle of a store's ACCESS phase.
        MemWriteEXMEM   = 1'b1;
        funct3EXMEM     = 3'b011;
        alu_resultEXMEM = 64'h20;
        write_dataEXMEM = 64'hAAAAAAAAAAAAAAAA;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midreset_stall", 64'(mem_stall), 64'd0);
        check("midreset_read_data", read_data, 64'd0);
        MemWriteEXMEM = 1'b0;
        exp_rd = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        do_op("ld_after_reset", 1'b1, 1'b0, 3'b011, 64'h20, 64'h0);

        do_op("sw_0x22", 1'b0, 1'b1, 3'b010, 64'h22, 64'hDEADBEEF);
        do_op("ld_0x20", 1'b1, 1'b0, 3'b011, 64'h20, 64'h0);

        // Random mix, issued back to back.
        for (int n = 0; n < 60; n++) begin
            logic        is_st = 1'($urandom_range(0, 1));
            logic [2:0]  f3    = is_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            logic [63:0] addr  = 64'($urandom_range(0, 2 * BYTES - 1));
            logic [63:0] wd    = {$urandom, $urandom};
            do_op(is_st ? "rand_st" : "rand_ld", ~is_st, is_st, f3, addr, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
